// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage access unit (master) and the data memory (slave).
// The memory answers each request with a single-cycle ack carrying the read word.
interface mem_access_unit_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: issues one byte-enabled bus transaction per access,
// stalls the pipeline until ack or timeout, and returns the sign/zero-extended load data.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic                      mem_mem_read,
  input  logic                      mem_mem_write,
  input  logic [2:0]                mem_funct3,
  input  logic [31:0]               mem_alu_result,
  input  logic [31:0]               mem_write_data,
  mem_access_unit_if.master         dbus,
  output logic [31:0]               mem_read_result,
  output logic                      mem_stall,
  output logic                      mem_fault,
  output logic [31:0]               fault_addr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        load_q, load_d;
  logic [31:0] result_q, result_d;
  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;

  logic        access;
  logic        sizeOk;
  logic        alignOk;
  logic        legal;
  logic [1:0]  off;
  logic [3:0]  laneBe;
  logic [31:0] laneWdata;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadResult;

  assign off    = mem_alu_result[1:0];
  assign access = mem_valid & (mem_mem_read | mem_mem_write);

  // Unsigned sizes exist only for loads; alignment follows the access width.
  always_comb begin
    sizeOk  = 1'b0;
    alignOk = 1'b0;
    case (mem_funct3)
      3'b000: begin sizeOk = 1'b1;           alignOk = 1'b1;       end
      3'b001: begin sizeOk = 1'b1;           alignOk = ~off[0];    end
      3'b010: begin sizeOk = 1'b1;           alignOk = (off == 2'b00); end
      3'b100: begin sizeOk = ~mem_mem_write; alignOk = 1'b1;       end
      3'b101: begin sizeOk = ~mem_mem_write; alignOk = ~off[0];    end
      default: begin sizeOk = 1'b0;          alignOk = 1'b0;       end
    endcase
    legal = sizeOk & alignOk & ~(mem_mem_read & mem_mem_write);
  end

  always_comb begin
    laneBe    = 4'b1111;
    laneWdata = mem_write_data;
    case (mem_funct3[1:0])
      2'b00: begin laneBe = 4'b0001 << off; laneWdata = {4{mem_write_data[7:0]}};  end
      2'b01: begin laneBe = 4'b0011 << off; laneWdata = {2{mem_write_data[15:0]}}; end
      default: begin laneBe = 4'b1111;      laneWdata = mem_write_data;            end
    endcase
  end

  // Load formatting uses the size and offset captured at issue, not the live inputs.
  always_comb begin
    loadByte = dbus.dbus_rdata[{off_q, 3'b000} +: 8];
    loadHalf = dbus.dbus_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  loadResult = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadResult = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadResult = {24'b0, loadByte};
      3'b101:  loadResult = {16'b0, loadHalf};
      default: loadResult = dbus.dbus_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    load_d   = load_q;
    result_d = result_q;
    fault_d  = 1'b0;
    faddr_d  = faddr_q;
    case (state_q)
      IDLE: begin
        if (access && legal) begin
          state_d = BUSY;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = mem_mem_write;
          addr_d  = {mem_alu_result[31:2], 2'b00};
          be_d    = laneBe;
          wdata_d = laneWdata;
          f3_d    = mem_funct3;
          off_d   = off;
          load_d  = mem_mem_read;
        end else if (access) begin
          fault_d  = 1'b1;
          faddr_d  = mem_alu_result;
          result_d = 32'd0;
        end
      end
      BUSY: begin
        if (dbus.dbus_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (load_q) result_d = loadResult;
        end else if (cnt_q == LAST_WAIT) begin
          req_d    = 1'b0;
          fault_d  = 1'b1;
          faddr_d  = {addr_q[31:2], off_q};
          result_d = 32'd0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      load_q   <= 1'b0;
      result_q <= 32'd0;
      fault_q  <= 1'b0;
      faddr_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      load_q   <= load_d;
      result_q <= result_d;
      fault_q  <= fault_d;
      faddr_q  <= faddr_d;
    end
  end

  // The IDLE term lets the pipeline freeze in the same cycle the access is seen.
  assign mem_stall = ~reset & (((state_q == IDLE) & access & legal) | (state_q == BUSY));

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_be    = be_q;
  assign dbus.dbus_wdata = wdata_q;

  assign mem_read_result = result_q;
  assign mem_fault       = fault_q;
  assign fault_addr      = faddr_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-bus controller for the 5-stage RISC-V core. It sits in the MEM stage between the EX/MEM pipeline register and `stage_memory`. It turns the MEM-stage load/store request into a word-aligned, byte-enabled bus transaction with an ack handshake, stalls the pipeline while the bus is busy, and formats load data (sign or zero extension) into `mem_read_result`. `stage_memory` latches that value on the first non-stalled edge.

## Interface
Parameters:
- MAX_WAIT, default 15: number of BUSY cycles without `dbus_ack` before the access is aborted with a fault (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_valid  in  1  an instruction occupies the MEM stage.
- mem_mem_read  in  1  instruction is a load.
- mem_mem_write  in  1  instruction is a store.
- mem_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_alu_result  in  32  effective byte address.
- mem_write_data  in  32  store data, right-aligned.
- dbus_req  out  1  bus request; held high until ack or abort.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word address: `{mem_alu_result[31:2], 2'b00}`.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  lane-shifted store data.
- dbus_ack  in  1  one-cycle completion strobe from memory.
- dbus_rdata  in  32  read word; valid when `dbus_ack` = 1.
- mem_read_result  out  32  formatted load result (registered).
- mem_stall  out  1  freeze IF..MEM and hold EX/MEM inputs stable.
- mem_fault  out  1  one-cycle pulse: misaligned access, illegal funct3, read+write together, or timeout.
- fault_addr  out  32  `mem_alu_result` captured on the fault pulse.

## Operation
States: IDLE, BUSY, DONE.
- **IDLE:** an access is `mem_valid & (mem_mem_read | mem_mem_write)`.
  - A legal access raises `mem_stall` combinationally in the same cycle. The next state is BUSY, and the bus outputs are registered at that edge.
  - An illegal access pulses `mem_fault` in the next cycle, issues no bus request, and does not stall. `mem_read_result` is written to 0.
  - Illegal means any of: halfword with `addr[0]` = 1; word with `addr[1:0]` ≠ 0; funct3 outside the allowed set (stores allow only 000/001/010); read and write both asserted.
- **BUSY:**
  - `dbus_req` = 1, `mem_stall` = 1, and all bus outputs are held stable.
  - The wait counter increments each cycle.
  - On `dbus_ack`: drop `dbus_req`, latch the formatted read data (loads only; stores leave `mem_read_result` unchanged), and go to DONE.
  - If the counter reaches MAX_WAIT without ack: drop `dbus_req`, pulse `mem_fault`, set `mem_read_result` to 0, and go to DONE.
  - If ack arrives in the same cycle the counter reaches MAX_WAIT, the ack wins and no fault is raised.
- **DONE:**
  - `mem_stall` = 0 for exactly one cycle so the pipeline advances.
  - The same instruction is still on the inputs and must not be re-issued.
  - Next state is always IDLE.
- **Store lanes (o = `addr[1:0]`):**
  - SB: `be = 4'b0001 << o`, wdata = byte replicated ×4.
  - SH: `be = 4'b0011 << o`, wdata = halfword replicated ×2.
  - SW: `be = 4'b1111`.
- **Load format:** select byte `rdata[8o+7:8o]` or halfword `rdata[16o[1]+15:16o[1]]`, then sign-extend (B/H) or zero-extend (BU/HU). Word passes through unchanged.
- `dbus_ack` in IDLE or DONE is ignored.
- `mem_valid` = 0 never starts an access, and does not cancel one already in BUSY.

## Timing
- **Reset values:**
  - State = IDLE, counter = 0.
  - `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_be`, `dbus_wdata`, `mem_read_result`, `mem_fault`, `fault_addr` = 0.
  - `mem_stall` = 0.
- Reset in BUSY drops `dbus_req` at that edge, and any late ack is ignored.
- **Best-case access (ack on the first BUSY cycle):**
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: BUSY, req = 1, ack = 1.
  - Cycle 2: DONE, stall = 0, `mem_read_result` valid.
  - Total: 3 cycles, 2 stall cycles.
- Each extra wait cycle adds one stall cycle.
- A timeout stalls for MAX_WAIT + 1 cycles; `mem_fault` is high during the DONE cycle.
- `mem_read_result` is stable from DONE until the next ack or fault.
- Back-to-back accesses: the new instruction is seen in the IDLE cycle immediately after DONE.

## Test plan
- **LW:** addr 0x100, rdata 0xDEADBEEF, ack on the first BUSY cycle → `dbus_addr` = 0x100, `be` = 1111, stall for 2 cycles, `mem_read_result` = 0xDEADBEEF in DONE, exactly one req assertion.
- **LB / LBU:** addr 0x103, rdata 0x80FF1234 → LB = 0xFFFFFF80; LBU = 0x00000080.
- **SB / SH:** SB addr 0x202, data 0x000000AB → `be` = 0100, wdata = 0xABABABAB, `we` = 1. SH addr 0x202, data 0x1234 → `be` = 1100, wdata = 0x12341234.
- **Misaligned:** LW at 0x101 → no `dbus_req`, `mem_stall` stays 0, one `mem_fault` pulse, `fault_addr` = 0x101, `mem_read_result` = 0.
- **Timeout:** MAX_WAIT = 4, no ack → req high for 4 cycles, then fault pulse, `mem_read_result` = 0, back to IDLE.
- **Ack at the limit / reset:** ack on wait cycle 4 → result valid, no fault. Separately, reset asserted mid-BUSY → all outputs 0 next cycle, and a later ack produces no DONE.
